// File: rtl/prefetch_fifo_sc.sv
`timescale 1ns/1ps
// Single-clock first-word-fall-through FIFO: registered-read RAM, one staging register,
// output register, fill level, almost-full/empty thresholds, synchronous flush, sticky errors.
module prefetch_fifo_sc #(
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH_WIDTH = 12,
  parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 4,
  parameter int AE_LEVEL    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  output logic                   wr_vld,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  // Handshake: a write is taken on a rising edge with wr_en && wr_vld, a pop with
  // rd_en && rd_vld; wr_vld depends on registered state only.

  localparam int CAP = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   CAP_L   = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0]   AF_L    = (DEPTH_WIDTH+1)'(AF_LEVEL);
  localparam logic [DEPTH_WIDTH:0]   AE_L    = (DEPTH_WIDTH+1)'(AE_LEVEL);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem [CAP];
  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_WIDTH:0]   ram_cnt, ram_cnt_next, level_next;
  logic [DATA_WIDTH-1:0]  ram_q, byp_data, s1_data;
  logic                   s1_vld, s1_byp;
  logic                   wr_acc, pop, take, s1_free, issue, bypass, ram_wr;

  always_comb begin
    wr_acc  = wr_en && wr_vld && !flush;
    pop     = rd_en && rd_vld && !flush;
    take    = s1_vld && (!rd_vld || pop);
    s1_free = !s1_vld || take;
    issue   = (ram_cnt != '0) && s1_free && !flush;
    // A write skips the RAM only when the RAM is empty and the output register stays
    // occupied, so back-to-back pops see no bubble while first-word latency stays 2.
    bypass  = wr_acc && (ram_cnt == '0) && s1_free && ((rd_vld && !pop) || take);
    ram_wr  = wr_acc && !bypass;
    s1_data = s1_byp ? byp_data : ram_q;

    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (wr_acc && !pop) begin
      level_next = level + CNT_ONE;
    end else if (!wr_acc && pop) begin
      level_next = level - CNT_ONE;
    end

    ram_cnt_next = ram_cnt;
    if (flush) begin
      ram_cnt_next = '0;
    end else if (ram_wr && !issue) begin
      ram_cnt_next = ram_cnt + CNT_ONE;
    end else if (!ram_wr && issue) begin
      ram_cnt_next = ram_cnt - CNT_ONE;
    end
  end

  // Storage array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (issue) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      s1_vld       <= 1'b0;
      s1_byp       <= 1'b0;
      byp_data     <= '0;
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      level        <= '0;
      wr_vld       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= level_next;
      ram_cnt      <= ram_cnt_next;
      wr_vld       <= (level_next != CAP_L);
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        s1_vld    <= 1'b0;
        s1_byp    <= 1'b0;
        rd_vld    <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (ram_wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (issue)  rd_ptr <= rd_ptr + PTR_ONE;
        if (bypass) byp_data <= wr_data;
        if (issue || bypass) begin
          s1_vld <= 1'b1;
          s1_byp <= bypass;
        end else if (take) begin
          s1_vld <= 1'b0;
        end
        // rd_data only moves on a refill, so it keeps the last word after the final pop.
        if (take) begin
          rd_vld  <= 1'b1;
          rd_data <= s1_data;
        end else if (pop) begin
          rd_vld  <= 1'b0;
        end
        if (wr_en && !wr_vld) overflow  <= 1'b1;
        if (rd_en && !rd_vld) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fifo_sc.sv
`timescale 1ns/1ps
// Self-checking bench for prefetch_fifo_sc: reference model of level/flags plus an
// expected-data queue that is filled on accepted writes and drained on pops.
module tb_prefetch_fifo_sc;

  localparam int DW  = 24;
  localparam int AW  = 12;
  localparam int CAP = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;

  int            n_chk = 0;
  int            n_bad = 0;
  int            mdl_level = 0;
  logic          mdl_ov = 1'b0;
  logic          mdl_uf = 1'b0;
  logic [DW-1:0] exp_q[$];

  prefetch_fifo_sc #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_vld(wr_vld), .wr_data(wr_data),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("level", 32'(level), 32'(mdl_level));
    chk("wr_vld", 32'(wr_vld), 32'(mdl_level < CAP));
    chk("almost_full", 32'(almost_full), 32'(mdl_level >= CAP - 4));
    chk("almost_empty", 32'(almost_empty), 32'(mdl_level <= 4));
    chk("overflow", 32'(overflow), 32'(mdl_ov));
    chk("underflow", 32'(underflow), 32'(mdl_uf));
  endtask

  task automatic model_clear();
    mdl_level = 0;
    mdl_ov = 1'b0;
    mdl_uf = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge with the given requests; returns 1ns after the edge with inputs idle.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    logic pv;
    logic acc;
    @(negedge clk);
    pv  = rd_vld;
    acc = we && (mdl_level < CAP);
    if (re && pv) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    if (acc) exp_q.push_back(wd);
    if (we && !acc) mdl_ov = 1'b1;
    if (re && !pv) mdl_uf = 1'b1;
    mdl_level = mdl_level + int'(acc) - int'(re && pv);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_model();
  endtask

  task automatic do_flush(input logic we, input logic re);
    @(negedge clk);
    flush = 1'b1;
    wr_en = we;
    wr_data = 24'h5A5A5A;
    rd_en = re;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_clear();
    chk_model();
    chk("flush_rd_vld", 32'(rd_vld), 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) step(1'b1, DW'(i), 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_vld"}, 32'(rd_vld), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
    chk({tag, "_uf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    int lvl_ref;
    logic [DW-1:0] d;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wr_vld", 32'(wr_vld), 32'd1);

    // T1: first-word latency of two edges
    step(1'b1, 24'hA5A5A5, 1'b0);
    chk("t1_vld_e0", 32'(rd_vld), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("t1_vld_e1", 32'(rd_vld), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("t1_vld_e2", 32'(rd_vld), 32'd1);
    chk("t1_data_e2", 32'(rd_data), 32'hA5A5A5);
    step(1'b0, '0, 1'b1);
    chk("t1_vld_after_pop", 32'(rd_vld), 32'd0);
    chk("t1_data_hold", 32'(rd_data), 32'hA5A5A5);

    // T2: fill to capacity, overflow attempt, in-order drain
    fill_seq(CAP);
    chk("t2_wr_vld", 32'(wr_vld), 32'd0);
    chk("t2_level", 32'(level), 32'(CAP));
    chk("t2_af", 32'(almost_full), 32'd1);
    step(1'b1, 24'hBADBAD, 1'b0);
    chk("t2_overflow", 32'(overflow), 32'd1);
    drain(CAP + 8);
    step(1'b0, '0, 1'b0);
    chk("t2_rd_vld_empty", 32'(rd_vld), 32'd0);
    chk("t2_ae", 32'(almost_empty), 32'd1);
    chk("t2_no_uf", 32'(underflow), 32'd0);
    do_flush(1'b0, 1'b0);

    // T3: one write and one pop per cycle across two pointer wraps
    for (int i = 0; i < 10000; i++) begin
      d = DW'($urandom_range(0, 24'hFFFFFF));
      step(1'b1, d, 1'b1);
      if (i >= 3) chk("t3_rd_vld", 32'(rd_vld), 32'd1);
      if (i == 20) lvl_ref = int'(level);
      if (i > 20) chk("t3_steady_level", 32'(level), 32'(lvl_ref));
    end
    drain(16);
    do_flush(1'b0, 1'b0);

    // T4: full with write and pop together
    fill_seq(CAP);
    step(1'b1, 24'h123456, 1'b1);
    chk("t4_level", 32'(level), 32'(CAP - 1));
    chk("t4_overflow", 32'(overflow), 32'd1);
    do_flush(1'b0, 1'b0);

    // T5: underflow, then flush wins over same-cycle requests
    step(1'b0, '0, 1'b1);
    chk("t5_underflow", 32'(underflow), 32'd1);
    chk("t5_level", 32'(level), 32'd0);
    do_flush(1'b1, 1'b1);
    chk("t5_uf_cleared", 32'(underflow), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("t5_write_ignored", 32'(level), 32'd0);
    chk("t5_wr_vld", 32'(wr_vld), 32'd1);

    // T6: asynchronous reset mid-stream
    fill_seq(100);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t6_pre_level", 32'(level), 32'd100);
    @(negedge clk);
    rd_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    step(1'b0, '0, 1'b0);
    chk_reset_vals("t6_release");
    chk("t6_wr_vld", 32'(wr_vld), 32'd1);

    // T6 follow-up: FIFO works normally after reset
    step(1'b1, 24'h00C0DE, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    drain(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
